// File: rtl/prefetch_fetcher_pkg.sv
// prefetch_fetcher_pkg: shared types, defaults and code image for the prefetch fetcher.
package prefetch_fetcher_pkg;

    localparam int WIDTH_DEF      = 32;
    localparam int INST_COUNT_DEF = 1024;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] pc;
        logic [WIDTH_DEF-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_STALL,
        S_FAULT
    } fetch_state_e;

    // Built-in code image: each word is distinct and derived from its word index.
    function automatic logic [31:0] rom_word(input int unsigned idx);
        return 32'h1000_0000 + idx * 32'h0001_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer with wrap-bit pointers and synchronous flush.
module fetch_fifo
    import prefetch_fetcher_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       data_i,
    output T                       data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T            mem [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        full;

    assign empty_o = wr_q == rd_q;
    assign full    = (wr_q ^ rd_q) == {1'b1, AW'(0)};
    assign count_o = wr_q - rd_q;
    assign data_o  = mem[rd_q[AW-1:0]];
    assign wr_d    = flush_i ? '0 : wr_q + (AW+1)'(push_i);
    assign rd_d    = flush_i ? '0 : rd_q + (AW+1)'(pop_i && !empty_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem[wr_q[AW-1:0]] <= data_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));

endmodule

// File: rtl/prefetch_fetcher.sv
// prefetch_fetcher: PC generation, registered ROM read and a DEPTH-entry prefetch queue
// feeding decode over valid/ready, with branch redirect and a sticky out-of-range fault.
module prefetch_fetcher
    import prefetch_fetcher_pkg::*;
#(
    parameter int               WIDTH      = WIDTH_DEF,
    parameter int               INST_COUNT = INST_COUNT_DEF,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   enable,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_inst,
    output logic [WIDTH-1:0]       out_pc,
    output logic                   fault,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int IDX_W = $clog2(INST_COUNT);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] inst;
    } entry_t;

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be 4-byte aligned");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] rom [INST_COUNT];
    for (genvar i = 0; i < INST_COUNT; i++) begin : g_rom
        assign rom[i] = WIDTH'(rom_word(i));
    end

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, infl_pc_q, rom_q;
    logic             inflight_q;
    logic             in_range, pop, push, credit, issue, empty, unused_bits;
    logic [OCC_W:0]   need;
    entry_t           head;

    assign unused_bits = ^redirect_pc[1:0];
    assign in_range    = ~|pc_q[WIDTH-1:IDX_W+2];
    assign pop         = out_valid && out_ready;
    assign push        = inflight_q && !redirect;
    // Slots committed after this cycle: queued + landing read - departing head.
    assign need        = (OCC_W+1)'(occupancy) + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
    assign credit      = need < (OCC_W+1)'(DEPTH);
    assign fault       = state_q == S_FAULT;
    assign issue       = enable && !fault && !redirect && credit && in_range;

    always_comb begin
        state_d = state_q;
        pc_d    = issue ? pc_q + WIDTH'(4) : pc_q;
        if (redirect) begin
            state_d = enable ? S_ISSUE : S_IDLE;
            pc_d    = {redirect_pc[WIDTH-1:2], 2'b00};
        end else if (state_q != S_FAULT) begin
            state_d = !enable ? S_IDLE : !in_range ? S_FAULT : !credit ? S_STALL : S_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            rom_q     <= rom[pc_q[IDX_W+1:2]];
            infl_pc_q <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .T    (entry_t)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (nreset),
        .flush_i(redirect),
        .push_i (push),
        .pop_i  (pop),
        .data_i ('{pc: infl_pc_q, inst: rom_q}),
        .data_o (head),
        .empty_o(empty),
        .count_o(occupancy)
    );

    assign out_valid = !empty;
    assign out_inst  = out_valid ? head.inst : '0;
    assign out_pc    = out_valid ? head.pc : '0;

endmodule

// File: tb/tb_prefetch_fetcher.sv
// tb_prefetch_fetcher: directed table plus hand sequences for backpressure, redirect,
// fault and asynchronous reset of the prefetch fetcher.
module tb_prefetch_fetcher;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        enable = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;
    logic [2:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        ready;
        logic        en;
        logic        v;
        logic [31:0] pc;
        logic [2:0]  occ;
    } vec_t;

    vec_t tbl [19];

    prefetch_fetcher #(
        .WIDTH     (32),
        .INST_COUNT(1024),
        .DEPTH     (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .enable     (enable),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .fault      (fault),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] rom_exp(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2) * 32'h0001_0003;
    endfunction

    function automatic vec_t mk(input logic r, e, v, input logic [31:0] pc, input logic [2:0] occ);
        vec_t x;
        x.ready = r;
        x.en    = e;
        x.v     = v;
        x.pc    = pc;
        x.occ   = occ;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_head(input string name, input logic v, input logic [31:0] pc,
                              input logic [2:0] occ);
        check({name, ".valid"}, 64'(out_valid), 64'(v));
        check({name, ".pc"}, 64'(out_pc), 64'(v ? pc : 32'h0));
        check({name, ".inst"}, 64'(out_inst), 64'(v ? rom_exp(pc) : 32'h0));
        check({name, ".occ"}, 64'(occupancy), 64'(occ));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        nreset      = 1'b0;
        enable      = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 0, 32'h00, 0);
        tbl[1]  = mk(1, 1, 1, 32'h00, 1);
        tbl[2]  = mk(1, 1, 1, 32'h04, 1);
        tbl[3]  = mk(1, 1, 1, 32'h08, 1);
        tbl[4]  = mk(0, 1, 1, 32'h08, 2);
        tbl[5]  = mk(0, 1, 1, 32'h08, 3);
        tbl[6]  = mk(0, 1, 1, 32'h08, 4);
        tbl[7]  = mk(0, 1, 1, 32'h08, 4);
        tbl[8]  = mk(1, 1, 1, 32'h0C, 3);
        tbl[9]  = mk(1, 1, 1, 32'h10, 3);
        tbl[10] = mk(1, 1, 1, 32'h14, 3);
        tbl[11] = mk(1, 1, 1, 32'h18, 3);
        tbl[12] = mk(1, 1, 1, 32'h1C, 3);
        tbl[13] = mk(1, 0, 1, 32'h20, 3);
        tbl[14] = mk(1, 0, 1, 32'h24, 2);
        tbl[15] = mk(1, 0, 1, 32'h28, 1);
        tbl[16] = mk(1, 0, 0, 32'h00, 0);
        tbl[17] = mk(1, 1, 0, 32'h00, 0);
        tbl[18] = mk(1, 1, 1, 32'h2C, 1);

        // Reset state, then the streaming/backpressure/enable table.
        do_reset();
        check_head("reset", 0, 32'h0, 0);
        check("reset.fault", 64'(fault), 64'(0));
        for (int i = 0; i < 19; i++) begin
            out_ready = tbl[i].ready;
            enable    = tbl[i].en;
            tick();
            check_head($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].pc, tbl[i].occ);
        end

        // Backpressure from reset: queue saturates holding ROM[0], then drains gap-free.
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b0;
        repeat (10) tick();
        check_head("bp_full", 1, 32'h0, 4);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_drain[%0d].pc", k), 64'(out_pc), 64'(k * 4));
            check($sformatf("bp_drain[%0d].inst", k), 64'(out_inst), 64'(rom_exp(32'(k * 4))));
            check($sformatf("bp_drain[%0d].valid", k), 64'(out_valid), 64'(1));
            tick();
        end

        // Redirect with three queued entries and one read in flight.
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b0;
        repeat (4) tick();
        check_head("rd_pre", 1, 32'h0, 3);
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect  = 1'b0;
        out_ready = 1'b1;
        check_head("rd_flush", 0, 32'h0, 0);
        tick();
        check_head("rd_nostale", 0, 32'h0, 0);
        tick();
        check_head("rd_target", 1, 32'h40, 1);
        tick();
        check_head("rd_next", 1, 32'h44, 1);

        // Redirect coinciding with a pop and a returning ROM word.
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check_head("rp_pre", 1, 32'h4, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check_head("rp_flush", 0, 32'h0, 0);
        tick();
        check_head("rp_gap", 0, 32'h0, 0);
        tick();
        check_head("rp_target", 1, 32'h100, 1);

        // Last ROM word, then sticky fault, then recovery by redirect to 0.
        redirect    = 1'b1;
        redirect_pc = 32'hFFC;
        tick();
        redirect = 1'b0;
        tick();
        check("lw_prefault", 64'(fault), 64'(0));
        tick();
        check_head("lw_word", 1, 32'hFFC, 1);
        check("lw_fault", 64'(fault), 64'(1));
        repeat (3) tick();
        check_head("lw_nopush", 0, 32'h0, 0);
        check("lw_sticky", 64'(fault), 64'(1));
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        check("lw_clear", 64'(fault), 64'(0));
        tick();
        tick();
        check_head("lw_resume", 1, 32'h0, 1);

        // Asynchronous reset mid-stream with a full queue.
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b0;
        repeat (8) tick();
        check("ar_pre.occ", 64'(occupancy), 64'(4));
        #2 nreset = 1'b0;
        #1;
        check_head("ar_async", 0, 32'h0, 0);
        check("ar_async.fault", 64'(fault), 64'(0));
        @(negedge clk);
        nreset    = 1'b1;
        out_ready = 1'b1;
        tick();
        check_head("ar_restart0", 0, 32'h0, 0);
        tick();
        check_head("ar_restart1", 1, 32'h0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
